// File: rtl/prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package prefetch_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + WORD_BYTES;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH x 32 instruction word FIFO; clear drops every entry by snapping the
// read pointer onto the write pointer.
module prefetch_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == CNT_ZERO);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; a push into a full FIFO is only taken alongside a pop.
    always_comb begin
        push_ok_s = push_i & (~full_o | pop_i);
        pop_ok_s  = pop_i & ~empty_o;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (clear_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clock) begin
        if (push_ok_s && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/prefetch_buffer.sv
// Sequential instruction prefetcher: streams words ahead of the core into a
// small FIFO, serves fetches from its head and restarts on redirect or flush.
module prefetch_buffer
    import prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_flush,
    output logic [31:0] fetch_rdata,
    output logic        fetch_ready,
    output logic        imemory_valid,
    output logic        imemory_instr,
    output logic [31:0] imemory_addr,
    output logic [31:0] imemory_wdata,
    output logic [3:0]  imemory_wstrb,
    input  logic [31:0] imemory_rdata,
    input  logic        imemory_ready
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

    fetch_state_e state_q;
    logic         imem_valid_q;
    logic [31:0]  imem_addr_q;
    logic [31:0]  head_addr_q, head_addr_d;
    logic [31:0]  pf_addr_q, pf_addr_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic         req_pend_q, req_pend_d;
    logic         discard_q, discard_d;

    logic [31:0]  head_data_s;
    logic [AW:0]  count_s;
    logic         full_s, empty_s;
    logic         ready_s, addr_match_s, miss_s, kill_s, hit_s, push_s, issue_ok_s;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (hit_s),
        .clear_i (kill_s),
        .wdata_i (imemory_rdata),
        .rdata_o (head_data_s),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // A miss or flush kills both the buffered words and any response landing this cycle.
    always_comb begin
        ready_s      = (state_q == WAIT) & imemory_ready;
        addr_match_s = (head_addr_q == req_addr_q);
        miss_s       = req_pend_q & ~addr_match_s;
        kill_s       = miss_s | fetch_flush;
        hit_s        = req_pend_q & addr_match_s & ~empty_s & ~fetch_flush;
        push_s       = ready_s & ~discard_q & ~kill_s & (~full_s | hit_s);
        issue_ok_s   = (count_s < CNT_DEPTH) & ~kill_s;
    end

    assign fetch_ready   = hit_s;
    assign fetch_rdata   = hit_s ? head_data_s : 32'h0000_0000;
    assign imemory_valid = imem_valid_q;
    assign imemory_addr  = imem_addr_q;
    assign imemory_instr = 1'b1;
    assign imemory_wdata = 32'h0000_0000;
    assign imemory_wstrb = 4'h0;

    // Memory request FSM with registered request outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            imem_valid_q <= 1'b0;
            imem_addr_q  <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_ok_s) begin
                        state_q      <= ISSUE;
                        imem_valid_q <= 1'b1;
                        imem_addr_q  <= pf_addr_q;
                    end else begin
                        state_q      <= IDLE;
                        imem_valid_q <= 1'b0;
                        imem_addr_q  <= 32'h0000_0000;
                    end
                end
                ISSUE: begin
                    state_q      <= WAIT;
                    imem_valid_q <= 1'b0;
                    imem_addr_q  <= 32'h0000_0000;
                end
                WAIT: begin
                    if (imemory_ready) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT;
                    end
                    imem_valid_q <= 1'b0;
                    imem_addr_q  <= 32'h0000_0000;
                end
                default: begin
                    state_q      <= IDLE;
                    imem_valid_q <= 1'b0;
                    imem_addr_q  <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Address tracking keeps pf_addr equal to head_addr plus one word per buffered entry.
    always_comb begin
        head_addr_d = head_addr_q;
        pf_addr_d   = pf_addr_q;
        if (miss_s) begin
            head_addr_d = req_addr_q;
            pf_addr_d   = req_addr_q;
        end else if (fetch_flush) begin
            head_addr_d = head_addr_q;
            pf_addr_d   = head_addr_q;
        end else begin
            if (hit_s) begin
                head_addr_d = next_word_addr(head_addr_q);
            end else begin
                head_addr_d = head_addr_q;
            end
            if (push_s) begin
                pf_addr_d = next_word_addr(pf_addr_q);
            end else begin
                pf_addr_d = pf_addr_q;
            end
        end
    end

    // An in-flight request whose response is still to come must be dropped on arrival.
    always_comb begin
        discard_d = discard_q;
        if (kill_s && ((state_q == ISSUE) || ((state_q == WAIT) && !imemory_ready))) begin
            discard_d = 1'b1;
        end else if (ready_s) begin
            discard_d = 1'b0;
        end else begin
            discard_d = discard_q;
        end
    end

    // A new fetch overrides whatever request is still pending.
    always_comb begin
        req_pend_d = req_pend_q;
        req_addr_d = req_addr_q;
        if (fetch_valid) begin
            req_pend_d = 1'b1;
            req_addr_d = fetch_addr;
        end else if (hit_s) begin
            req_pend_d = 1'b0;
            req_addr_d = req_addr_q;
        end else begin
            req_pend_d = req_pend_q;
            req_addr_d = req_addr_q;
        end
    end

    // Address, discard and request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_addr_q <= 32'h0000_0000;
            pf_addr_q   <= 32'h0000_0000;
            req_addr_q  <= 32'h0000_0000;
            req_pend_q  <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            head_addr_q <= head_addr_d;
            pf_addr_q   <= pf_addr_d;
            req_addr_q  <= req_addr_d;
            req_pend_q  <= req_pend_d;
            discard_q   <= discard_d;
        end
    end

endmodule
